traffic_request_conditioner: RTL

Upstream front end for the traffic-light controller. It synchronizes and debounces the side-road vehicle loop detector and the optional pedestrian button, and holds each accepted request until the controller acknowledges service. It also generates the one-cycle `tick` enable that the controller uses as its phase-timing time base.

---
 rtl/traffic_pkg.sv | 17 +
 rtl/traffic_request_conditioner_if.sv | 23 ++
 rtl/traffic_debounce.sv | 74 +++++++
 rtl/traffic_request_conditioner.sv | 89 ++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light request front end.
package traffic_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned TICK_DIV_DEF        = 10;
  localparam int unsigned REQ_COUNT_W         = 8;
  localparam int unsigned DB_CNT_W            = 8;
  localparam int unsigned TICK_CNT_W          = 16;

  typedef enum logic [1:0] {
    DB_IDLE      = 2'd0,
    DB_ARMING    = 2'd1,
    DB_HELD      = 2'd2,
    DB_RELEASING = 2'd3
  } db_state_e;

endpackage

// File: rtl/traffic_request_conditioner_if.sv
// Request/tick bus between the request conditioner (slave) and the controller side (master).
interface traffic_request_conditioner_if;
  import traffic_pkg::*;

  logic                   sensor_raw;
  logic                   ped_btn_raw;
  logic                   req_ack;
  logic                   tick;
  logic                   side_req;
  logic                   ped_req;
  logic [REQ_COUNT_W-1:0] req_count;

  modport master (
    output sensor_raw, ped_btn_raw, req_ack,
    input  tick, side_req, ped_req, req_count
  );

  modport slave (
    input  sensor_raw, ped_btn_raw, req_ack,
    output tick, side_req, ped_req, req_count
  );

endinterface

// File: rtl/traffic_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits one combinational event per accepted press.
module traffic_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic event_c_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  db_state_e           state_q, state_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event is Mealy so the request latch captures it on the accepting edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    event_c_o = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (sync2_q) begin
          state_d = DB_ARMING;
          cnt_d   = '0;
        end
      end
      DB_ARMING: begin
        if (!sync2_q) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DB_HELD;
          event_c_o = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
      DB_HELD: begin
        if (!sync2_q) begin
          state_d = DB_RELEASING;
          cnt_d   = '0;
        end
      end
      DB_RELEASING: begin
        if (sync2_q) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/traffic_request_conditioner.sv
// Debounced side-road/pedestrian request latches, saturating event count and tick divider.
// Pedestrian channel is built only when TRAFFIC_PED_REQ_EN is defined.
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_DIV        = TICK_DIV_DEF
) (
  input logic                          clk,
  input logic                          rst,
  traffic_request_conditioner_if.slave bus
);

  localparam logic [TICK_CNT_W-1:0]  TICK_LAST = TICK_CNT_W'(TICK_DIV - 1);
  localparam logic [REQ_COUNT_W-1:0] CNT_MAX   = '1;

  logic                   side_event_c;
  logic                   ped_event_c;
  logic                   side_req_q, side_req_d;
  logic                   ped_req_q, ped_req_d;
  logic [REQ_COUNT_W-1:0] count_q, count_d;
  logic [TICK_CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic                   tick_q, tick_d;
  logic [1:0]             count_inc;
  logic [REQ_COUNT_W:0]   count_sum;

  traffic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_side_db (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (bus.sensor_raw),
    .event_c_o (side_event_c)
  );

`ifdef TRAFFIC_PED_REQ_EN
  traffic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_db (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (bus.ped_btn_raw),
    .event_c_o (ped_event_c)
  );
`else
  logic ped_btn_unused;
  assign ped_btn_unused = bus.ped_btn_raw;
  assign ped_event_c    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      side_req_q <= 1'b0;
      ped_req_q  <= 1'b0;
      count_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      side_req_q <= side_req_d;
      ped_req_q  <= ped_req_d;
      count_q    <= count_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  // Set beats acknowledge; count saturates rather than wrapping.
  always_comb begin
    side_req_d = side_req_q;
    ped_req_d  = ped_req_q;
    if (side_event_c)      side_req_d = 1'b1;
    else if (bus.req_ack)  side_req_d = 1'b0;
    if (ped_event_c)       ped_req_d  = 1'b1;
    else if (bus.req_ack)  ped_req_d  = 1'b0;

    count_inc = {1'b0, side_event_c} + {1'b0, ped_event_c};
    count_sum = {1'b0, count_q} + (REQ_COUNT_W + 1)'(count_inc);
    count_d   = count_sum[REQ_COUNT_W] ? CNT_MAX : count_sum[REQ_COUNT_W-1:0];

    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_CNT_W'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  assign bus.tick      = tick_q;
  assign bus.side_req  = side_req_q;
`ifdef TRAFFIC_PED_REQ_EN
  assign bus.ped_req   = ped_req_q;
`else
  assign bus.ped_req   = 1'b0;
`endif
  assign bus.req_count = count_q;

endmodule
